my_cpu: RTL and testbench
=========================

# my_cpu

Single-cycle Hack CPU core: it decodes 16-bit Hack instructions into the six ALU control bits plus destination and jump fields. It also holds the A, D and PC registers. The core is the control end of the ALU interface: it generates zx/nx/zy/ny/f/no, consumes the ALU result, and derives its own zr/ng flags. It sits between instruction ROM (addressed by `pc`) and data RAM (`inM`/`outM`/`addressM`/`writeM`).

## Interface
- `PC_WIDTH`, 15, width of `pc` and `addressM`. Fixed at 15 for Hack; other values are unsupported.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high; clears A, D and PC.
- `instruction` in 16: current instruction word from ROM at `pc`.
- `inM` in 16: data RAM read value at `addressM`.
- `stall` in 1: when 1, the instruction is not executed. No register updates; `writeM` forced 0.
- `outM` out 16: ALU result. Combinational.
- `writeM` out 1: RAM write strobe. Combinational.
- `addressM` out 15: A[14:0], the current A before this cycle's update.
- `pc` out 15: program counter register.

## Operation
- Bit 15 = 0 is an A-instruction:
  - A <= {1'b0, instruction[14:0]}.
  - D unchanged; `writeM`=0; PC <= PC+1.
- Bit 15 = 1 is a C-instruction. Bits 14:13 are ignored.
- C-instruction fields:
  - a = bit 12.
  - zx,nx,zy,ny,f,no = bits 11:6.
  - dA,dD,dM = bits 5:3.
  - jlt,jeq,jgt = bits 2:0.
- ALU operands: x = D; y = a ? `inM` : A.
- ALU function, in order:
  - zx zeroes x; nx inverts x; zy zeroes y; ny inverts y.
  - f selects x+y (16-bit, carry discarded) when 1, x&y when 0.
  - no inverts the result.
- Flags, computed locally from `outM`:
  - zr = (`outM`==0).
  - ng = `outM`[15] (MSB, two's-complement sign).
  - Bit 0 is never used as a sign.
- Destinations (C-instruction, not stalled):
  - dA: A <= `outM`.
  - dD: D <= `outM`.
  - dM: `writeM`=1.
  - Any combination is allowed simultaneously.
- Jump: take = (jlt&ng) | (jeq&zr) | (jgt&~zr&~ng).
  - PC <= take ? A_old[14:0] : PC+1.
  - The target is always the A value from before the edge, even when dA=1 in the same instruction.
- PC increment wraps 0x7FFF -> 0x0000.
- `stall`=1: A, D and PC hold; `writeM`=0. `outM` is still driven.

## Timing
- All registers update on the rising `clk` edge when `reset`=0 and `stall`=0.
- Reset is asynchronous:
  - A=0, D=0, PC=0 immediately on `reset` assertion, without waiting for an edge.
  - Registers hold while asserted; `writeM`=0 while asserted.
  - Reset values: `pc`=0, `addressM`=0. `outM` follows instruction/`inM` with A=D=0.
- First instruction executes on the first rising edge after `reset` deasserts.
- Latency:
  - `outM`, `writeM` and `addressM` are valid combinationally within the cycle the instruction is presented.
  - A, D and PC updates are visible one edge later.
- RAM handshake: RAM samples `outM` at `addressM` on the same edge when `writeM`=1. No read latency; `inM` must be valid in the same cycle.
- Reset mid-cycle with `writeM` high: `writeM` drops immediately and no write is issued.

## Test plan
- Async reset: run to PC=5, A=9, assert `reset` between edges.
  - Required: `pc`=0, `addressM`=0, `writeM`=0 before the next edge.
  - First post-release edge gives `pc`=1.
- A-instruction: 0x0015 at `pc`=0.
  - Required: after the edge, `addressM`=21 and `pc`=1.
  - 0x7FFF loads A=0x7FFF; bit 15 stays clear.
- Arithmetic and store, starting from A=21:
  - 0xEC10 (D=A) gives D=21.
  - Then 0xE088 (M=D+A) gives `outM`=42, `writeM`=1, `addressM`=21 in that cycle.
- Jumps, with A=100 and 0xE302 (D;JEQ):
  - D=0: `pc`=100.
  - D=5: `pc`=old+1.
  - D=0x8000 with 0xE304 (D;JLT): `pc`=100, confirming ng is the MSB.
- Simultaneous dest A and jump: A=7, 0xEDE7 (A=A+1;JMP).
  - Required: `pc`=7 (old A), A=8 after the edge.
- Stall and wrap:
  - `stall`=1 with 0xE088: `writeM`=0; A, D and PC unchanged across 3 edges.
  - PC=0x7FFF with any A-instruction: `pc`=0x0000 next.

Source files
------------

// File: rtl/my_cpu.sv
// my_cpu: single-cycle Hack CPU core.
// Decodes A- and C-instructions, drives the ALU control bits, computes the
// ALU result and its zr/ng flags, and holds the A, D and PC registers.
//
// RAM strobe: writeM is a one-cycle write strobe with no ready back-pressure.
// RAM captures outM at addressM on the rising edge where writeM=1. inM is
// read combinationally in the same cycle. When stall=1 or reset=1, writeM is
// forced low and no register updates, so no write can be issued.
module my_cpu #(
  parameter int PC_WIDTH = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         instruction,
  input  logic [15:0]         inM,
  input  logic                stall,
  output logic [15:0]         outM,
  output logic                writeM,
  output logic [PC_WIDTH-1:0] addressM,
  output logic [PC_WIDTH-1:0] pc
);

  // Architectural registers.
  logic [15:0]         a_q, a_d;
  logic [15:0]         d_q, d_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;

  // Decoded instruction fields.
  logic is_c;
  logic sel_m;
  logic zx, nx, zy, ny, fn, no;
  logic dst_a, dst_d, dst_m;
  logic jlt, jeq, jgt;

  // ALU datapath.
  logic [15:0] x_zx, x_nx, y_sel, y_zy, y_ny, alu_f, alu_out;
  logic        zr, ng, take;
  logic        exec_en;

  // Bits 14:13 of a C-instruction carry no meaning.
  logic unused_bits;
  assign unused_bits = ^instruction[14:13];

  // Field decode.
  always_comb begin
    is_c  = instruction[15];
    sel_m = instruction[12];
    zx    = instruction[11];
    nx    = instruction[10];
    zy    = instruction[9];
    ny    = instruction[8];
    fn    = instruction[7];
    no    = instruction[6];
    dst_a = instruction[5];
    dst_d = instruction[4];
    dst_m = instruction[3];
    jlt   = instruction[2];
    jeq   = instruction[1];
    jgt   = instruction[0];
  end

  // Hack ALU: x=D, y=A or M, preprocess, add/and, optional final invert.
  always_comb begin
    x_zx    = zx ? 16'h0000 : d_q;
    x_nx    = nx ? ~x_zx : x_zx;
    y_sel   = sel_m ? inM : a_q;
    y_zy    = zy ? 16'h0000 : y_sel;
    y_ny    = ny ? ~y_zy : y_zy;
    alu_f   = fn ? (x_nx + y_ny) : (x_nx & y_ny);
    alu_out = no ? ~alu_f : alu_f;
  end

  // Flags and jump decision; ng is the two's-complement sign (MSB).
  always_comb begin
    zr   = (alu_out == 16'h0000);
    ng   = alu_out[15];
    take = is_c & ((jlt & ng) | (jeq & zr) | (jgt & ~zr & ~ng));
  end

  // Outputs to data RAM; addressM reflects A before this cycle's update.
  always_comb begin
    exec_en  = ~stall & ~reset;
    outM     = alu_out;
    writeM   = is_c & dst_m & exec_en;
    addressM = a_q[PC_WIDTH-1:0];
    pc       = pc_q;
  end

  // Next-state: A/D loads and PC sequencing; jump target uses the old A.
  always_comb begin
    a_d  = a_q;
    d_d  = d_q;
    pc_d = pc_q + 1'b1;
    if (!is_c) begin
      a_d = {1'b0, instruction[14:0]};
    end else begin
      if (dst_a) a_d = alu_out;
      if (dst_d) d_d = alu_out;
      if (take)  pc_d = a_q[PC_WIDTH-1:0];
    end
  end

  // Register update; stall holds everything, reset clears asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q  <= '0;
      d_q  <= '0;
      pc_q <= '0;
    end else if (!stall) begin
      a_q  <= a_d;
      d_q  <= d_d;
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_my_cpu.sv
// tb_my_cpu: directed-vector bench for the Hack CPU core.
module tb_my_cpu;

  logic        clk;
  logic        reset;
  logic [15:0] instruction;
  logic [15:0] inM;
  logic        stall;
  logic [15:0] outM;
  logic        writeM;
  logic [14:0] addressM;
  logic [14:0] pc;

  int checks;
  int errors;

  my_cpu #(.PC_WIDTH(15)) dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .inM         (inM),
    .stall       (stall),
    .outM        (outM),
    .writeM      (writeM),
    .addressM    (addressM),
    .pc          (pc)
  );

  // Clock: 10-unit period, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point.
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  // Present an instruction and let one rising edge execute it.
  task automatic exec(input logic [15:0] ins);
    instruction = ins;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    stall       = 1'b0;
    inM         = 16'h0000;
    instruction = 16'hE088;

    // Reset state.
    #12;
    check("rst_pc",     {1'b0, pc},       16'h0000);
    check("rst_addr",   {1'b0, addressM}, 16'h0000);
    check("rst_writeM", {15'h0, writeM},  16'h0000);
    check("rst_outM",   outM,             16'h0000);
    reset = 1'b0;

    // A-instruction.
    exec(16'h0015);
    check("ainst_addr", {1'b0, addressM}, 16'd21);
    check("ainst_pc",   {1'b0, pc},       16'd1);

    // D=A then M=D+A.
    exec(16'hEC10);
    check("dA_outM", outM,       16'd21);
    check("dA_pc",   {1'b0, pc}, 16'd2);
    instruction = 16'hE088;
    #1;
    check("store_outM",   outM,             16'd42);
    check("store_writeM", {15'h0, writeM},  16'h0001);
    check("store_addr",   {1'b0, addressM}, 16'd21);

    // y operand from inM when a=1 (D=M).
    inM         = 16'h0100;
    instruction = 16'hFC10;
    #1;
    check("mread_outM",   outM,            16'h0100);
    check("mread_writeM", {15'h0, writeM}, 16'h0000);
    inM         = 16'h0000;

    // Stall: no write, no register update across 3 edges.
    instruction = 16'hE088;
    stall       = 1'b1;
    #1;
    check("stall_writeM", {15'h0, writeM}, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    check("stall_pc",   {1'b0, pc},       16'd2);
    check("stall_addr", {1'b0, addressM}, 16'd21);
    check("stall_outM", outM,             16'd42);
    stall = 1'b0;
    exec(16'hE088);
    check("post_stall_pc", {1'b0, pc}, 16'd3);

    // JEQ taken with D=0.
    exec(16'h0064);
    exec(16'hEA90);
    check("d0_outM", outM, 16'h0000);
    exec(16'hE302);
    check("jeq_taken_pc", {1'b0, pc}, 16'd100);

    // JEQ not taken with D=5.
    exec(16'h0005);
    exec(16'hEC10);
    exec(16'h0064);
    instruction = 16'hE302;
    #1;
    check("jeq_nt_outM",   outM,            16'd5);
    check("jeq_nt_writeM", {15'h0, writeM}, 16'h0000);
    exec(16'hE302);
    check("jeq_nt_pc", {1'b0, pc}, 16'd104);

    // JLT with D=0x8000: ng is the MSB.
    exec(16'h7FFF);
    check("a7fff_addr", {1'b0, addressM}, 16'h7FFF);
    exec(16'hEC10);
    exec(16'hE7D0);
    check("dinc_pc", {1'b0, pc}, 16'd107);
    exec(16'h0064);
    instruction = 16'hE304;
    #1;
    check("jlt_outM", outM, 16'h8000);
    exec(16'hE304);
    check("jlt_pc", {1'b0, pc}, 16'd100);

    // A=A+1;JMP jumps to the old A.
    exec(16'h0007);
    instruction = 16'hEDE7;
    #1;
    check("ainc_outM", outM, 16'd8);
    exec(16'hEDE7);
    check("ajmp_pc",   {1'b0, pc},       16'd7);
    check("ajmp_addr", {1'b0, addressM}, 16'd8);

    // PC wrap 0x7FFF -> 0.
    exec(16'h7FFF);
    exec(16'hEA87);
    check("wrap_pre_pc", {1'b0, pc}, 16'h7FFF);
    exec(16'h0003);
    check("wrap_pc",   {1'b0, pc},       16'h0000);
    check("wrap_addr", {1'b0, addressM}, 16'd3);

    // Async reset between edges with writeM high.
    repeat (5) exec(16'h0009);
    check("pre_rst_pc",   {1'b0, pc},       16'd5);
    check("pre_rst_addr", {1'b0, addressM}, 16'd9);
    instruction = 16'hE088;
    #1;
    check("pre_rst_writeM", {15'h0, writeM}, 16'h0001);
    reset = 1'b1;
    #1;
    check("arst_pc",     {1'b0, pc},       16'h0000);
    check("arst_addr",   {1'b0, addressM}, 16'h0000);
    check("arst_writeM", {15'h0, writeM},  16'h0000);
    check("arst_outM",   outM,             16'h0000);
    @(posedge clk);
    #1;
    check("arst_hold_pc", {1'b0, pc}, 16'h0000);
    reset = 1'b0;
    exec(16'h0001);
    check("rel_pc",   {1'b0, pc},       16'd1);
    check("rel_addr", {1'b0, addressM}, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #20000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
